// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO feeding the UART transmitter one word at a time via send/busy,
// with level, sticky overflow and an all-sent interrupt pulse.
module uart_tx_fifo_ctrl #(
    parameter int DATA_UART = 8,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 en_i,
    input  logic                 flush_i,
    input  logic                 wr_valid_i,
    input  logic [DATA_UART-1:0] wr_data_i,
    output logic                 wr_ready_o,
    output logic [DATA_UART-1:0] tx_data_o,
    output logic                 tx_send_o,
    input  logic                 tx_busy_i,
    output logic [FIFO_AW:0]     fifo_count_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 overflow_o,
    output logic                 done_irq_o
);
    localparam int DEPTH = 2**FIFO_AW;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
    state_t               state;
    logic [DATA_UART-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wptr, rptr;
    logic                 push, pop;
    assign empty_o    = fifo_count_o == '0;
    assign full_o     = fifo_count_o == (FIFO_AW+1)'(DEPTH);
    assign wr_ready_o = ~full_o;
    assign push       = wr_valid_i & ~full_o & ~flush_i;
    // the head word leaves the FIFO only once the transmitter has taken it
    assign pop        = (state == WAIT_BUSY) & tx_busy_i & ~empty_o & ~flush_i;
    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wr_data_i;
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr         <= '0;
            rptr         <= '0;
            fifo_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (flush_i) begin
            wptr         <= '0;
            rptr         <= '0;
            fifo_count_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            wptr         <= push ? wptr + 1'b1 : wptr;
            rptr         <= pop ? rptr + 1'b1 : rptr;
            fifo_count_o <= fifo_count_o + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            overflow_o   <= overflow_o | (wr_valid_i & full_o);
        end
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            tx_data_o  <= '0;
            tx_send_o  <= 1'b0;
            done_irq_o <= 1'b0;
        end else begin
            done_irq_o <= 1'b0;
            case (state)
                IDLE: if (~empty_o & en_i & ~tx_busy_i & ~flush_i) begin
                    tx_data_o <= mem[rptr];
                    tx_send_o <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    tx_send_o <= 1'b0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: state <= tx_busy_i ? WAIT_DONE : (en_i ? WAIT_BUSY : IDLE);
                WAIT_DONE: if (!tx_busy_i) begin
                    state      <= IDLE;
                    done_irq_o <= empty_o;
                end
                default: begin
                    state     <= IDLE;
                    tx_send_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
